instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the instruction and PC width.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 64, giving the instruction memory size in words.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 6, giving the word index width (log2 MEM_DEPTH).
REQ-004 i_clock  input  1  clock; all state SHALL update on its rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_pc  input  DATA_WIDTH  current PC from the PC register.
REQ-007 i_start  input  1  one-cycle pulse; leaves IDLE and begins fetching.
REQ-008 i_stall  input  1  hazard stall; holds the IF/ID register.
REQ-009 i_flush  input  1  branch/jump taken; squashes the instruction being fetched.
REQ-010 i_load_en, i_load_addr[ADDR_WIDTH-1:0], i_load_data[DATA_WIDTH-1:0]  input  program-load write port.
REQ-011 o_pc_plus4  output  DATA_WIDTH  combinational i_pc + 4, sent to the PC mux.
REQ-012 o_instruction, o_pc_plus4_id  output  DATA_WIDTH each  IF/ID register contents.
REQ-013 o_valid  output  1  o_instruction is a real fetched instruction.
REQ-014 o_pc_en  output  1  PC register may advance this cycle: high in RUN, low otherwise, and low while i_stall is high.
REQ-015 o_halt, o_misaligned  output  1 each  sticky status flags.
REQ-016 o_fetch_count  output  32  count of instructions fetched (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, RUN and HALTED; IDLE->RUN on i_start; RUN->HALTED when a HALT word (all ones) is registered; HALTED SHALL persist until reset.
REQ-018 Memory writes SHALL occur only in IDLE when i_load_en=1; i_load_en SHALL be ignored in RUN and HALTED.
REQ-019 Memory read SHALL be combinational at word index i_pc[ADDR_WIDTH+1:2], so the IF/ID register gets the word one cycle after i_pc is presented.
REQ-020 o_pc_plus4 SHALL wrap modulo 2^DATA_WIDTH.
REQ-021 IF/ID update priority in RUN SHALL be flush > stall > normal; flush and stall together SHALL act as flush.
REQ-022 On flush, the register SHALL load instruction 0x00000000 with o_valid=0.
REQ-023 On stall, all IF/ID outputs SHALL hold their values.
REQ-024 On a normal cycle, the register SHALL load the memory word and i_pc+4 with o_valid=1.
REQ-025 If i_pc >= MEM_DEPTH*4, the block SHALL register the HALT word, making out-of-range fetch equivalent to HALT.
REQ-026 If i_pc[1:0] != 0 in RUN, the block SHALL set o_misaligned, register a NOP with o_valid=0 and enter HALTED.
REQ-027 In IDLE and HALTED, the IF/ID register SHALL load a NOP with o_valid=0.
REQ-028 In HALTED, o_halt SHALL be 1.
REQ-029 The HALT word itself SHALL be presented with o_valid=1 exactly once.

Reset
REQ-030 On reset, the FSM SHALL enter IDLE.
REQ-031 On reset, o_instruction, o_pc_plus4_id, o_valid, o_halt, o_misaligned, o_fetch_count and o_pc_en SHALL all be 0.
REQ-032 Reset SHALL NOT clear memory contents.
REQ-033 Reset SHALL take priority over all other inputs, including mid-load and mid-run.

Configuration
REQ-034 With macro IF_FETCH_COUNTER_EN defined, o_fetch_count SHALL increment by 1 on every cycle that loads o_valid=1, wrapping at 2^32.
REQ-035 Without IF_FETCH_COUNTER_EN, o_fetch_count SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-036 Load words 0x20010005@0 and 0x20020003@1 in IDLE, pulse i_start, drive i_pc=0 then 4 -> o_instruction shows 0x20010005 then 0x20020003 with o_pc_plus4_id 4 then 8, o_valid=1.
REQ-037 In RUN with i_stall=1 for 2 cycles and i_pc=8 -> IF/ID outputs unchanged and o_pc_en=0 for both cycles.
REQ-038 Drive i_flush=1 and i_stall=1 together at i_pc=8 -> o_instruction=0x00000000, o_valid=0.
REQ-039 HALT word 0xFFFFFFFF at index 2 fetched -> word registered once with o_valid=1, then o_halt=1, o_pc_en=0, NOPs follow; a later i_load_en write is ignored.
REQ-040 Drive i_pc=0x00000006 in RUN -> o_misaligned=1, o_halt=1; with i_pc=0x100 and MEM_DEPTH=64 -> HALT behaviour.
REQ-041 Assert reset mid-run after 3 fetches -> all outputs 0, state IDLE, memory word 0 still reads back 0x20010005 after a new i_start; with IF_FETCH_COUNTER_EN defined, count=3 before the reset and 0 after it.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage with a loadable instruction memory, IF/ID register and IDLE/RUN/HALTED control.
// Optional fetch counter is enabled by defining IF_FETCH_COUNTER_EN.
module instruction_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_start,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_load_en,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic [DATA_WIDTH-1:0] o_pc_plus4,
  output logic [DATA_WIDTH-1:0] o_instruction,
  output logic [DATA_WIDTH-1:0] o_pc_plus4_id,
  output logic                  o_valid,
  output logic                  o_pc_en,
  output logic                  o_halt,
  output logic                  o_misaligned,
  output logic [31:0]           o_fetch_count
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  localparam logic [DATA_WIDTH-1:0] MEM_BYTES = DATA_WIDTH'(MEM_DEPTH * 4);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] fetch_word, instruction, pc_plus4_id, n_inst, n_pc4;
  logic valid, misaligned, n_valid, n_mis;
  assign o_pc_plus4 = i_pc + DATA_WIDTH'(4);
  // Fetches past the end of memory read as the all-ones HALT word.
  assign fetch_word = (i_pc < MEM_BYTES) ? mem[i_pc[ADDR_WIDTH+1:2]] : '1;
  assign o_instruction = instruction;
  assign o_pc_plus4_id = pc_plus4_id;
  assign o_valid = valid;
  assign o_misaligned = misaligned;
  assign o_halt = state == HALTED;
  assign o_pc_en = state == RUN && !i_stall;
  always_ff @(posedge i_clock)
    if (!i_reset && state == IDLE && i_load_en) mem[i_load_addr] <= i_load_data;
  always_comb begin
    state_n = state;
    n_inst = '0;
    n_pc4 = '0;
    n_valid = 1'b0;
    n_mis = misaligned;
    if (state == IDLE) begin
      state_n = i_start ? RUN : IDLE;
    end else if (state == RUN && !i_flush) begin
      if (i_stall) begin
        n_inst = instruction;
        n_pc4 = pc_plus4_id;
        n_valid = valid;
      end else if (i_pc[1:0] != 2'b00) begin
        n_mis = 1'b1;
        state_n = HALTED;
      end else begin
        n_inst = fetch_word;
        n_pc4 = o_pc_plus4;
        n_valid = 1'b1;
        state_n = (&fetch_word) ? HALTED : RUN;
      end
    end
  end
  always_ff @(posedge i_clock)
    if (i_reset) begin
      state <= IDLE;
      instruction <= '0;
      pc_plus4_id <= '0;
      valid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state <= state_n;
      instruction <= n_inst;
      pc_plus4_id <= n_pc4;
      valid <= n_valid;
      misaligned <= n_mis;
    end
`ifdef IF_FETCH_COUNTER_EN
  logic [31:0] count;
  always_ff @(posedge i_clock)
    if (i_reset) count <= '0;
    else if (state == RUN && !i_flush && !i_stall && i_pc[1:0] == 2'b00) count <= count + 32'd1;
  assign o_fetch_count = count;
`else
  assign o_fetch_count = '0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of load, fetch, stall, flush, halt, misalign and reset behaviour.
module tb_instruction_fetch;
`ifdef IF_FETCH_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, start, stall, flush, load_en;
  logic [31:0] pc, load_data;
  logic [5:0] load_addr;
  logic [31:0] pc_plus4, instruction, pc_plus4_id, fetch_count;
  logic valid, pc_en, halt, misaligned;
  int checks = 0;
  int errors = 0;
  instruction_fetch dut (
    .i_clock(clk), .i_reset(rst), .i_pc(pc), .i_start(start), .i_stall(stall),
    .i_flush(flush), .i_load_en(load_en), .i_load_addr(load_addr), .i_load_data(load_data),
    .o_pc_plus4(pc_plus4), .o_instruction(instruction), .o_pc_plus4_id(pc_plus4_id),
    .o_valid(valid), .o_pc_en(pc_en), .o_halt(halt), .o_misaligned(misaligned),
    .o_fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [5:0] a, input logic [31:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    rst = 1'b1; start = 0; stall = 0; flush = 0; load_en = 0; pc = 0; load_addr = 0; load_data = 0;
    step();
    step();
    rst = 1'b0;
    chk("rst_inst", instruction, 32'h0);
    chk("rst_pc4id", pc_plus4_id, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_halt", {31'b0, halt}, 32'd0);
    chk("rst_mis", {31'b0, misaligned}, 32'd0);
    chk("rst_pc_en", {31'b0, pc_en}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("pc_plus4", pc_plus4, 32'd4);
    pc = 32'hFFFF_FFFC;
    #1;
    chk("pc_plus4_wrap", pc_plus4, 32'h0);
    pc = 0;
    load(6'd0, 32'h2001_0005);
    load(6'd1, 32'h2002_0003);
    load(6'd2, 32'hFFFF_FFFF);
    load(6'd3, 32'h0000_0033);
    rst = 1'b1; load_en = 1'b1; load_addr = 6'd3; load_data = 32'h0000_0099;
    step();
    rst = 1'b0; load_en = 1'b0;
    chk("idle_valid", {31'b0, valid}, 32'd0);
    chk("idle_pc_en", {31'b0, pc_en}, 32'd0);
    go();
    chk("run_pc_en", {31'b0, pc_en}, 32'd1);
    pc = 0;
    step();
    chk("f0_inst", instruction, 32'h2001_0005);
    chk("f0_pc4id", pc_plus4_id, 32'd4);
    chk("f0_valid", {31'b0, valid}, 32'd1);
    pc = 4;
    step();
    chk("f1_inst", instruction, 32'h2002_0003);
    chk("f1_pc4id", pc_plus4_id, 32'd8);
    chk("f1_valid", {31'b0, valid}, 32'd1);
    pc = 8; stall = 1'b1;
    #1;
    chk("stall_pc_en_comb", {31'b0, pc_en}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_inst", instruction, 32'h2002_0003);
      chk("stall_pc4id", pc_plus4_id, 32'd8);
      chk("stall_valid", {31'b0, valid}, 32'd1);
      chk("stall_pc_en", {31'b0, pc_en}, 32'd0);
    end
    flush = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    chk("flush_inst", instruction, 32'h0);
    chk("flush_valid", {31'b0, valid}, 32'd0);
    pc = 12;
    step();
    chk("rst_blocks_load", instruction, 32'h0000_0033);
    chk("f3_valid", {31'b0, valid}, 32'd1);
    chk("count3", fetch_count, CNT_EN ? 32'd3 : 32'd0);
    do_reset();
    chk("mid_rst_inst", instruction, 32'h0);
    chk("mid_rst_pc4id", pc_plus4_id, 32'h0);
    chk("mid_rst_valid", {31'b0, valid}, 32'd0);
    chk("mid_rst_pc_en", {31'b0, pc_en}, 32'd0);
    chk("mid_rst_count", fetch_count, 32'd0);
    go();
    pc = 0;
    step();
    chk("mem_kept", instruction, 32'h2001_0005);
    chk("count1", fetch_count, CNT_EN ? 32'd1 : 32'd0);
    pc = 8;
    step();
    chk("halt_word", instruction, 32'hFFFF_FFFF);
    chk("halt_word_valid", {31'b0, valid}, 32'd1);
    chk("halt_set", {31'b0, halt}, 32'd1);
    chk("halt_pc_en", {31'b0, pc_en}, 32'd0);
    pc = 12;
    step();
    chk("halted_nop", instruction, 32'h0);
    chk("halted_valid", {31'b0, valid}, 32'd0);
    chk("halted_sticky", {31'b0, halt}, 32'd1);
    chk("halted_count", fetch_count, CNT_EN ? 32'd2 : 32'd0);
    load(6'd0, 32'hDEAD_BEEF);
    do_reset();
    go();
    pc = 32'h6;
    step();
    chk("mis_flag", {31'b0, misaligned}, 32'd1);
    chk("mis_halt", {31'b0, halt}, 32'd1);
    chk("mis_valid", {31'b0, valid}, 32'd0);
    step();
    chk("mis_sticky", {31'b0, misaligned}, 32'd1);
    do_reset();
    chk("mis_rst", {31'b0, misaligned}, 32'd0);
    go();
    pc = 0;
    step();
    chk("halted_load_ignored", instruction, 32'h2001_0005);
    pc = 32'h100;
    step();
    chk("oor_inst", instruction, 32'hFFFF_FFFF);
    chk("oor_valid", {31'b0, valid}, 32'd1);
    chk("oor_halt", {31'b0, halt}, 32'd1);
    step();
    chk("oor_after_valid", {31'b0, valid}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
